// File: rtl/drom_pkg.sv
// Shared DROM definitions: load FSM states, access-size codes and byte-lane geometry.
package drom_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] FUNCT3_BYTE = 3'b000;
  localparam logic [2:0] FUNCT3_HALF = 3'b001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    CHK     = 3'd4,
    TAIL    = 3'd5,
    DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/drom_byte_packer.sv
// Little-endian byte-to-word packer: a 2-bit lane counter steering each accepted byte
// into its slot of a 32-bit register; word_valid flags the byte that completes a word.
module drom_byte_packer
  import drom_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (byte_valid) begin
      word[{lane, 3'b000} +: 8] <= byte_data;
      lane                      <= lane + 2'd1;
    end
  end

  assign word_valid = byte_valid && (lane == 2'(LANES - 1));

endmodule

// File: rtl/drom_load_ctrl.sv
// Host-driven DROM loader: packs a byte stream into words, writes them through the drom_unit
// external port and stalls the core meanwhile. DROM_LOAD_CHKSUM_EN adds a trailing checksum word.
module drom_load_ctrl
  import drom_pkg::*;
#(
  parameter int ADDR_DEPTH = 768,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_start_i,
  input  logic                  load_abort_i,
  input  logic [ADDR_WIDTH:0]   load_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  ext_acc_o,
  output logic                  we_o,
  output logic [31:0]           din_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_stall_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  state_t              state, state_next;
  logic [ADDR_WIDTH:0] len_q, word_cnt_q;
  logic                err_q;
  logic                start_ok, abort_ok, accept, word_valid, last_word;
  logic [31:0]         packed_word;

  // Abort beats a simultaneous start in IDLE, so the start is only taken when no abort is present.
  assign start_ok  = (state == IDLE) && load_start_i && !load_abort_i;
  assign abort_ok  = (state != IDLE) && load_abort_i;
  assign accept    = byte_valid_i && byte_ready_o;
  assign last_word = ((word_cnt_q + 1'b1) == len_q);

  drom_byte_packer u_packer (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (start_ok || abort_ok),
    .byte_valid (accept),
    .byte_data  (byte_data_i),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if ((load_words_i == '0) || (load_words_i > MAX_WORDS)) state_next = DONE;
          else                                                     state_next = ARM;
        end
      end
      ARM:     state_next = COLLECT;
      COLLECT: if (word_valid) state_next = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef DROM_LOAD_CHKSUM_EN
          state_next = CHK;
`else
          state_next = TAIL;
`endif
        end else begin
          state_next = COLLECT;
        end
      end
      CHK:     if (word_valid) state_next = TAIL;
      TAIL:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_ok) state_next = IDLE;
  end

`ifdef DROM_LOAD_CHKSUM_EN
  logic [31:0] sum_q;
  logic        chk_bad;

  // The checksum word completes with the byte on the bus, so compare against it directly.
  assign chk_bad = (state == CHK) && word_valid && ({byte_data_i, packed_word[23:0]} != sum_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             sum_q <= '0;
    else if (start_ok)       sum_q <= '0;
    else if (state == WRITE) sum_q <= sum_q + packed_word;
  end
`else
  logic chk_bad;
  assign chk_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        len_q      <= load_words_i;
        word_cnt_q <= '0;
        err_q      <= (load_words_i > MAX_WORDS);
      end else if (abort_ok) begin
        err_q <= 1'b1;
      end else begin
        if (state == WRITE) word_cnt_q <= word_cnt_q + 1'b1;
        if (chk_bad)        err_q      <= 1'b1;
      end
    end
  end

  assign byte_ready_o = (state == COLLECT) || (state == CHK);
  assign ext_acc_o    = (state == ARM) || (state == COLLECT) || (state == WRITE) || (state == TAIL);
  assign we_o         = (state == WRITE);
  assign din_o        = packed_word;
  assign busy_o       = (state != IDLE);
  assign cpu_stall_o  = busy_o;
  assign done_o       = (state == DONE);
  assign err_o        = err_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_drom_load_ctrl.sv
// Self-checking bench for drom_load_ctrl: table of whole loads plus abort/reset sequences,
// with a small DROM model tracking the external address counter. Honours DROM_LOAD_CHKSUM_EN.
module tb_drom_load_ctrl;

`ifdef DROM_LOAD_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic [10:0] load_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready_o, ext_acc_o, we_o, busy_o, done_o, err_o, cpu_stall_o;
  logic [31:0] din_o;
  logic [10:0] word_cnt_o;

  int checks = 0;
  int errors = 0;

  int ext_seen, done_cnt, wr_cnt, data_err, proto_err, drom_addr, cur_pat;
  bit prev_ext, prev_we;

  always #5 clk = ~clk;

  drom_load_ctrl #(.ADDR_DEPTH(768), .ADDR_WIDTH(10)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_start_i (load_start),
    .load_abort_i (load_abort),
    .load_words_i (load_words),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready_o),
    .ext_acc_o    (ext_acc_o),
    .we_o         (we_o),
    .din_o        (din_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_stall_o  (cpu_stall_o),
    .word_cnt_o   (word_cnt_o)
  );

  typedef struct {
    logic [10:0] words;
    int          gap;
    int          pat;
    bit          bad;
    bit          exp_err;
    int          exp_writes;
    bit          exp_ext;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] expWord(input int n, input int pat);
    if (pat == 1) return 32'(n + 1);
    return {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)};
  endfunction

  function automatic logic [7:0] byteAt(input int idx, input int words, input int pat,
                                        input logic [31:0] chk);
    logic [31:0] w;
    w = (idx < 4*words) ? expWord(idx / 4, pat) : chk;
    return 8'(w >> (8 * (idx % 4)));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // DROM model: rising ext_acc resets its address; each we stores at the address and advances it.
  task automatic sample();
    if (ext_acc_o && !prev_ext) begin
      drom_addr = 0;
      if (we_o) proto_err++;
    end
    if (ext_acc_o) ext_seen = 1;
    if (we_o) begin
      if (!ext_acc_o || prev_we) proto_err++;
      if (drom_addr != wr_cnt || din_o != expWord(wr_cnt, cur_pat)) data_err++;
      drom_addr++;
      wr_cnt++;
    end
    if (done_o) done_cnt++;
    prev_ext = ext_acc_o;
    prev_we  = we_o;
  endtask

  task automatic applyStimulus(input logic [10:0] words, input int nbytes, input int gap,
                               input int pat, input bit bad, input bit stop_on_bytes);
    int          idx;
    bit          accepted;
    logic [31:0] chk;
    chk = 32'(bad);
    for (int n = 0; n < int'(words); n++) chk += expWord(n, pat);
    cur_pat = pat; ext_seen = 0; done_cnt = 0; wr_cnt = 0; data_err = 0; proto_err = 0;
    drom_addr = 0; prev_ext = 1'b0; prev_we = 1'b0;
    @(negedge clk);
    load_words = words;
    load_start = 1'b1;
    idx = 0;
    accepted = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      load_start = 1'b0;
      sample();
      if (accepted) idx++;
      if (done_o || (stop_on_bytes && idx >= nbytes)) begin
        byte_valid = 1'b0;
        break;
      end
      byte_valid = (idx < nbytes) && (gap == 0 || (c % 2) == 0);
      byte_data  = byteAt(idx, int'(words), pat, chk);
      accepted   = byte_valid && byte_ready_o;
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{11'd3,   0, 0, 1'b0, 1'b0,   3, 1'b1};
    vecs[1] = '{11'd3,   1, 0, 1'b0, 1'b0,   3, 1'b1};
    vecs[2] = '{11'd1,   0, 0, 1'b0, 1'b0,   1, 1'b1};
    vecs[3] = '{11'd0,   0, 0, 1'b0, 1'b0,   0, 1'b0};
    vecs[4] = '{11'd769, 0, 0, 1'b0, 1'b1,   0, 1'b0};
    vecs[5] = '{11'd768, 0, 0, 1'b0, 1'b0, 768, 1'b1};
    vecs[6] = '{11'd2,   0, 1, 1'b0, 1'b0,   2, 1'b1};
    vecs[7] = '{11'd2,   0, 1, 1'b1, CHK_EN, 2, 1'b1};

    #3;
    checkOutput("reset_outputs",
                64'({byte_ready_o, ext_acc_o, we_o, busy_o, done_o, err_o, cpu_stall_o,
                     word_cnt_o, din_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].words, 4*int'(vecs[i].words) + 4, vecs[i].gap, vecs[i].pat,
                    vecs[i].bad, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_busy", i),      64'(busy_o),     64'd0);
      checkOutput($sformatf("v%0d_err", i),       64'(err_o),      64'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d_done", i),      64'(done_cnt),   64'd1);
      checkOutput($sformatf("v%0d_writes", i),    64'(wr_cnt),     64'(vecs[i].exp_writes));
      checkOutput($sformatf("v%0d_word_cnt", i),  64'(word_cnt_o), 64'(vecs[i].exp_writes));
      checkOutput($sformatf("v%0d_data", i),      64'(data_err),   64'd0);
      checkOutput($sformatf("v%0d_protocol", i),  64'(proto_err),  64'd0);
      checkOutput($sformatf("v%0d_ext_seen", i),  64'(ext_seen),   64'(vecs[i].exp_ext));
    end

    applyStimulus(11'd3, 6, 0, 0, 1'b0, 1'b1);
    load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0;
    checkOutput("abort_ext_acc",    64'(ext_acc_o),    64'd0);
    checkOutput("abort_ready_we",   64'({byte_ready_o, we_o}), 64'd0);
    checkOutput("abort_busy",       64'(busy_o),       64'd0);
    checkOutput("abort_err",        64'(err_o),        64'd1);
    checkOutput("abort_word_cnt",   64'(word_cnt_o),   64'd1);
    checkOutput("abort_no_done",    64'({done_o, 32'(done_cnt)}), 64'd0);

    load_words = 11'd1;
    load_start = 1'b1;
    load_abort = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_abort = 1'b0;
    checkOutput("abort_start_idle_busy", 64'(busy_o), 64'd0);
    checkOutput("abort_start_idle_err",  64'(err_o),  64'd1);

    applyStimulus(11'd1, 8, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("restart_err",    64'(err_o),    64'd0);
    checkOutput("restart_done",   64'(done_cnt), 64'd1);
    checkOutput("restart_writes", 64'(wr_cnt),   64'd1);
    checkOutput("restart_data",   64'(data_err), 64'd0);

    applyStimulus(11'd3, 5, 0, 0, 1'b0, 1'b1);
    checkOutput("pre_reset_busy", 64'(busy_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midload_reset_outputs",
                64'({byte_ready_o, ext_acc_o, we_o, busy_o, done_o, err_o, cpu_stall_o,
                     word_cnt_o, din_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", 64'({busy_o, ext_acc_o}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
